// File: rtl/lead_one_normalizer_if.sv
// lead_one_normalizer_if: operand/result handshake bundle for the leading-one normaliser
interface lead_one_normalizer_if #(
  parameter int W  = 49,
  parameter int PW = $clog2(W)
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] msb_loc;
  logic [PW-1:0] shamt;
  logic [W-1:0]  norm;
  logic          zero;
  modport master (
    output flush, in_valid, in_a, out_ready,
    input  in_ready, out_valid, msb_loc, shamt, norm, zero
  );
  modport slave (
    input  flush, in_valid, in_a, out_ready,
    output in_ready, out_valid, msb_loc, shamt, norm, zero
  );
endinterface

// File: rtl/lead_one_normalizer.sv
// lead_one_normalizer: iterative leading-one detector scanning CHUNK bits per cycle from the MSB end
module lead_one_normalizer #(
  parameter int W     = 49,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  lead_one_normalizer_if.slave bus
);
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int PW     = $clog2(W);
  localparam int KW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK > 1 ? $clog2(CHUNK) : 1;
  localparam int WP     = NCHUNK * CHUNK;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  op_q, op_d, norm_q, norm_d;
  logic [PW-1:0] msb_q, msb_d, shamt_q, shamt_d, loc;
  logic          zero_q, zero_d;
  logic [WP-1:0] ext;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0] hi;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= KW'(NCHUNK - 1);
      op_q    <= '0;
      msb_q   <= '0;
      shamt_q <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      msb_q   <= msb_d;
      shamt_q <= shamt_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
    end
  end
  // Zero-extend so a partial top chunk reads zeros above bit W-1
  always_comb begin
    ext   = WP'(op_q);
    chunk = ext[int'(k_q)*CHUNK +: CHUNK];
    hi    = '0;
    for (int i = 0; i < CHUNK; i++) if (chunk[i]) hi = CW'(i);
    loc   = PW'(int'(k_q) * CHUNK + int'(hi));
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    msb_d   = msb_q;
    shamt_d = shamt_q;
    norm_d  = norm_q;
    zero_d  = zero_q;
    if (bus.flush) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_d = SCAN;
          op_d    = bus.in_a;
          k_d     = KW'(NCHUNK - 1);
        end
        SCAN: if (chunk != '0 || k_q == '0) begin
          state_d = DONE;
          zero_d  = chunk == '0;
          msb_d   = zero_d ? '0 : loc;
          shamt_d = zero_d ? '0 : PW'(W - 1) - loc;
          norm_d  = zero_d ? '0 : op_q << shamt_d;
        end else k_d = k_q - 1'b1;
        default: if (bus.out_ready) state_d = IDLE;
      endcase
  end
  always_comb begin
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.msb_loc   = msb_q;
    bus.shamt     = shamt_q;
    bus.norm      = norm_q;
    bus.zero      = zero_q;
  end
endmodule

// File: tb/tb_lead_one_normalizer.sv
// tb_lead_one_normalizer: scoreboard bench over CHUNK = 8 (directed) and 1/7/49 (sweep)
module tb_lead_one_normalizer;
  typedef struct {
    int          msb;
    int          shamt;
    logic [48:0] norm;
    logic        zero;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[4], fl[4], ordy[4], rdy[4], ov[4], zr[4];
  logic [48:0] ia[4], nm[4];
  logic [5:0]  ml[4], sh[4];
  exp_t        qs[4][$];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  function automatic int chv(int i);
    return i == 0 ? 8 : i == 1 ? 1 : i == 2 ? 7 : 49;
  endfunction
  function automatic void chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, req);
    end
  endfunction
  function automatic exp_t model(logic [48:0] a, int c);
    exp_t e;
    int   nc = (49 + c - 1) / c;
    e.msb = 0; e.shamt = 0; e.norm = '0; e.zero = 1'b1; e.lat = nc;
    for (int i = 0; i < 49; i++) if (a[i]) begin e.msb = i; e.zero = 1'b0; end
    if (!e.zero) begin
      e.shamt = 48 - e.msb;
      e.norm  = a << e.shamt;
      e.lat   = nc - e.msb / c;
    end
    return e;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int C = g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 7 : 49;
    lead_one_normalizer_if #(.W(49)) b();
    lead_one_normalizer #(.W(49), .CHUNK(C)) u (.clk(clk), .rst(rst), .bus(b));
    assign b.in_valid  = iv[g];
    assign b.in_a      = ia[g];
    assign b.flush     = fl[g];
    assign b.out_ready = ordy[g];
    assign rdy[g] = b.in_ready;
    assign ov[g]  = b.out_valid;
    assign ml[g]  = b.msb_loc;
    assign sh[g]  = b.shamt;
    assign nm[g]  = b.norm;
    assign zr[g]  = b.zero;
    int   edges = 0;
    logic prev  = 1'b0;
    exp_t e;
    always @(posedge clk) edges <= (b.in_valid && b.in_ready && !b.flush) ? 0 : edges + 1;
    always @(negedge clk) begin
      if (b.out_valid && !prev) begin
        if (qs[g].size() == 0) chk($sformatf("c%0d_unexpected_out", C), 64'(b.out_valid), 0);
        else begin
          e = qs[g].pop_front();
          chk($sformatf("c%0d_msb", C), 64'(b.msb_loc), 64'(e.msb));
          chk($sformatf("c%0d_shamt", C), 64'(b.shamt), 64'(e.shamt));
          chk($sformatf("c%0d_norm", C), 64'(b.norm), 64'(e.norm));
          chk($sformatf("c%0d_zero", C), 64'(b.zero), 64'(e.zero));
          chk($sformatf("c%0d_latency", C), 64'(edges), 64'(e.lat));
        end
      end
      prev <= b.out_valid;
    end
  end
  task automatic send(int idx, logic [48:0] a, exp_t e, bit push);
    for (int t = 0; t < 200 && !rdy[idx]; t++) @(negedge clk);
    chk($sformatf("c%0d_in_ready_wait", chv(idx)), 64'(rdy[idx]), 1);
    ia[idx] = a;
    iv[idx] = 1'b1;
    if (push) qs[idx].push_back(e);
    @(negedge clk);
    iv[idx] = 1'b0;
    ia[idx] = ~a;
  endtask
  task automatic wait_out(int idx);
    for (int t = 0; t < 200 && !ov[idx]; t++) @(negedge clk);
    chk($sformatf("c%0d_out_valid_wait", chv(idx)), 64'(ov[idx]), 1);
  endtask
  task automatic run(int idx, logic [48:0] a, exp_t e);
    send(idx, a, e, 1'b1);
    wait_out(idx);
    @(negedge clk);
  endtask
  initial begin
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1; ia[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(rdy[0]), 1);
    chk("rst_out_valid", 64'(ov[0]), 0);
    chk("rst_msb", 64'(ml[0]), 0);
    chk("rst_shamt", 64'(sh[0]), 0);
    chk("rst_norm", 64'(nm[0]), 0);
    chk("rst_zero", 64'(zr[0]), 0);
    run(0, 49'h1_0000_0000_0000, '{48, 0, 49'h1_0000_0000_0000, 1'b0, 1});
    run(0, 49'h1, '{0, 48, 49'h1_0000_0000_0000, 1'b0, 7});
    run(0, 49'h0, '{0, 0, 49'h0, 1'b1, 7});
    run(0, 49'h0_0000_0300_0000, '{25, 23, 49'h1_8000_0000_0000, 1'b0, 4});
    ordy[0] = 1'b0;
    send(0, 49'h1FF, '{8, 40, 49'h1_FF00_0000_0000, 1'b0, 6}, 1'b1);
    wait_out(0);
    iv[0] = 1'b1;
    ia[0] = 49'h3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(ov[0]), 1);
      chk("bp_in_ready", 64'(rdy[0]), 0);
      chk("bp_msb", 64'(ml[0]), 8);
      chk("bp_norm", 64'(nm[0]), 64'h1_FF00_0000_0000);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(rdy[0]), 1);
    chk("rel_out_valid", 64'(ov[0]), 0);
    run(0, 49'h80, '{7, 41, 49'h1_0000_0000_0000, 1'b0, 7});
    send(0, 49'h1, model(49'h1, 8), 1'b0);
    repeat (2) @(negedge clk);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    chk("flush_in_ready", 64'(rdy[0]), 1);
    chk("flush_out_valid", 64'(ov[0]), 0);
    repeat (10) @(negedge clk);
    chk("flush_no_out", 64'(ov[0]), 0);
    chk("flush_keep_msb", 64'(ml[0]), 7);
    fl[0] = 1'b1;
    iv[0] = 1'b1;
    ia[0] = 49'h5;
    @(negedge clk);
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    chk("flush_idle_reject", 64'(rdy[0]), 1);
    send(0, 49'h1, model(49'h1, 8), 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(rdy[0]), 1);
    chk("arst_out_valid", 64'(ov[0]), 0);
    chk("arst_msb", 64'(ml[0]), 0);
    chk("arst_shamt", 64'(sh[0]), 0);
    chk("arst_norm", 64'(nm[0]), 0);
    chk("arst_zero", 64'(zr[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_out", 64'(ov[0]), 0);
    for (int idx = 1; idx < 4; idx++) begin
      run(idx, 49'h0, model(49'h0, chv(idx)));
      run(idx, 49'h1, model(49'h1, chv(idx)));
      run(idx, 49'h1_0000_0000_0000, model(49'h1_0000_0000_0000, chv(idx)));
      run(idx, '1, model('1, chv(idx)));
      for (int n = 0; n < 10; n++) begin
        logic [48:0] a;
        r = {$urandom(), $urandom()};
        a = 49'(r >> $urandom_range(0, 63));
        run(idx, a, model(a, chv(idx)));
      end
    end
    repeat (3) @(negedge clk);
    chk("leftover", 64'(qs[0].size() + qs[1].size() + qs[2].size() + qs[3].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lead_one_normalizer.md
# lead_one_normalizer

Parametrised, iterative leading-one detector and normaliser for the multi-cycle floating-point datapath. It accepts a W-bit unsigned mantissa over a valid/ready handshake and scans it CHUNK bits per cycle, starting at the most significant end. It returns the leading-one position, the left-shift amount and the normalised mantissa, with a zero flag. It sits between the mantissa multiplier product register and the exponent-adjust stage.

## Interface
- W, 49, operand width in bits (W ≥ 2)
- CHUNK, 8, bits examined per scan cycle (1 ≤ CHUNK ≤ W)
- Derived: NCHUNK = ceil(W/CHUNK); PW = $clog2(W)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous abort; returns to IDLE, discards operation
- in_valid  input  1  operand valid
- in_ready  output  1  high only in IDLE
- in_a  input  W  operand
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts result
- msb_loc  output  PW  index of highest set bit of operand; 0 when zero
- shamt  output  PW  W-1-msb_loc; 0 when zero
- norm  output  W  in_a << shamt (leading one at bit W-1); 0 when zero
- zero  output  1  operand was all zeros

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid, capture in_a into the operand register, set chunk index k=NCHUNK-1 and go to SCAN.
- Chunk k covers bits [k*CHUNK+CHUNK-1 : k*CHUNK]. Bit positions ≥ W read as 0, so the top chunk may be partial.
- SCAN: examine chunk k each cycle.
  - Chunk nonzero: msb_loc = k*CHUNK + highest set bit within the chunk. Register msb_loc, shamt, norm and zero=0, then go to DONE.
  - Chunk zero and k>0: decrement k and stay in SCAN.
  - Chunk zero and k==0: register zero=1 and msb_loc=shamt=norm=0, then go to DONE.
- DONE: out_valid=1 and all outputs held stable. On out_ready, go to IDLE.
- No accept in DONE, so back-to-back throughput is at best one operand per latency+2 cycles.
- flush is sampled in every state and has priority over all transitions:
  - next state is IDLE and out_valid goes low;
  - result registers keep their last values;
  - flush in IDLE together with in_valid: the operand is not accepted.
- Result registers change only on the SCAN→DONE transition.
- Width rules:
  - msb_loc is always < W;
  - shamt = W-1-msb_loc is computed in PW bits with no overflow;
  - norm keeps exactly W bits, and bits shifted past W-1 cannot be set.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, msb_loc=0, shamt=0, norm=0, zero=0, k=NCHUNK-1.
- Reset asserted mid-SCAN or in DONE aborts immediately. No result is produced.
- Edge E0 is the accept edge (in_valid & in_ready). If the leading one lies in chunk NCHUNK-i, out_valid is high after edge Ei.
  - Latency = i edges: minimum 1, maximum NCHUNK.
  - Zero operand: latency NCHUNK.
- The DONE→IDLE transition happens on the edge where out_valid & out_ready. in_ready is high the following cycle.
- CHUNK=W gives a single scan cycle, latency 1 for all inputs.
- in_a is not sampled after E0, so changes to it during SCAN/DONE are ignored.

## Test plan
- W=49, CHUNK=8 (NCHUNK=7), in_a=1<<48 -> out_valid after 1 edge; msb_loc=48, shamt=0, norm=1<<48, zero=0.
- W=49, CHUNK=8, in_a=1 -> out_valid after 7 edges; msb_loc=0, shamt=48, norm=1<<48. Also in_a=0 -> out_valid after 7 edges; zero=1, msb_loc=0, shamt=0, norm=0.
- W=49, CHUNK=8, in_a=0x0_0000_0300_0000 (bits 25,24) -> chunk 3, out_valid after 4 edges; msb_loc=25, shamt=23, norm=0x1_8000_0000_0000.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid and outputs stable, in_ready=0, new in_valid ignored. Then release -> in_ready=1 the next cycle, and a second operand (in_a=0x80) yields msb_loc=7.
- Abort: assert flush during the 3rd SCAN cycle of in_a=1 -> IDLE next cycle, no out_valid ever. Repeat with async rst mid-SCAN -> all outputs at reset values immediately.
- Sweep CHUNK ∈ {1, 7, 49} with random operands against a reference model -> correct msb_loc/shamt/norm/zero, and latency equals the number of chunks scanned.
